// File: rtl/lcd_tick_timer.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_tick_timer
//  Description : Multi-channel programmable tick timebase for the LCD control
//                path. Each channel divides clk by (div+1), counts ticks up to
//                a limit, then saturates (one-shot) or wraps (free-running).
//                Optional feature macro: TICK_WRAP_MODE_EN (enables per-channel
//                wrap mode; when undefined every channel saturates and the
//                mode input is ignored).
//  Revision    : 1.0 - initial release
// ============================================================================
module lcd_tick_timer #(
   parameter int NCH   = 2,
   parameter int DIV_W = 20,
   parameter int CNT_W = 17
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NCH-1:0]         start,
   input  logic [NCH*DIV_W-1:0]   div_i,
   input  logic [NCH*CNT_W-1:0]   limit_i,
   input  logic [NCH-1:0]         mode,
   output logic [NCH*CNT_W-1:0]   ticks_o,
   output logic [NCH-1:0]         tick_o,
   output logic [NCH-1:0]         done_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

`ifndef TICK_WRAP_MODE_EN
   // Without wrap support the mode input has no function at all.
   logic w_mode_unused;
   assign w_mode_unused = ^mode;
`endif

   for (genvar k = 0; k < NCH; k++) begin : g_ch
      state_t             r_state, w_state_nxt;
      logic [DIV_W-1:0]   r_div, w_div_nxt;
      logic [DIV_W-1:0]   r_sub, w_sub_nxt;
      logic [CNT_W-1:0]   r_limit, w_limit_nxt;
      logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
      logic [CNT_W-1:0]   w_cnt_inc;
      logic               r_tick, w_tick_nxt;
      logic               r_done, w_done_nxt;
      logic               w_wrap_in;   // mode requested at start time
      logic               w_wrap_lat;  // mode latched for the current run
      logic [DIV_W-1:0]   w_div_in;
      logic [CNT_W-1:0]   w_limit_in;

      assign w_div_in   = div_i[k*DIV_W +: DIV_W];
      assign w_limit_in = limit_i[k*CNT_W +: CNT_W];
      assign w_cnt_inc  = r_cnt + CNT_W'(1);

`ifdef TICK_WRAP_MODE_EN
      logic r_mode, w_mode_nxt;

      // Mode shadow: captured only when the channel leaves IDLE.
      always_comb begin
         w_mode_nxt = r_mode;
         if (r_state == S_IDLE && start[k])
            w_mode_nxt = mode[k];
      end

      // Mode shadow register.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)
            r_mode <= 1'b0;
         else
            r_mode <= w_mode_nxt;
      end

      assign w_wrap_in  = mode[k];
      assign w_wrap_lat = r_mode;
`else
      assign w_wrap_in  = 1'b0;
      assign w_wrap_lat = 1'b0;
`endif

      // Next-state and registered-output logic for one channel.
      always_comb begin
         w_state_nxt = r_state;
         w_div_nxt   = r_div;
         w_limit_nxt = r_limit;
         w_sub_nxt   = r_sub;
         w_cnt_nxt   = r_cnt;
         w_tick_nxt  = 1'b0;
         w_done_nxt  = 1'b0;

         case (r_state)
            S_IDLE: begin
               w_sub_nxt = '0;
               w_cnt_nxt = '0;
               if (start[k]) begin
                  w_div_nxt   = w_div_in;
                  w_limit_nxt = w_limit_in;
                  // A zero limit in saturate mode is complete before any tick.
                  if (!w_wrap_in && (w_limit_in == '0)) begin
                     w_state_nxt = S_DONE;
                     w_done_nxt  = 1'b1;
                  end else begin
                     w_state_nxt = S_RUN;
                  end
               end
            end

            S_RUN: begin
               if (r_sub == r_div) begin
                  w_sub_nxt  = '0;
                  w_tick_nxt = 1'b1;
                  if (w_wrap_lat) begin
                     if (r_cnt == r_limit) begin
                        w_cnt_nxt  = '0;
                        w_done_nxt = 1'b1;
                     end else begin
                        w_cnt_nxt = w_cnt_inc;
                     end
                  end else begin
                     w_cnt_nxt = w_cnt_inc;
                     if (w_cnt_inc == r_limit) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                     end
                  end
               end else begin
                  w_sub_nxt = r_sub + DIV_W'(1);
               end
            end

            S_DONE: begin
               w_done_nxt = 1'b1;
            end

            default: begin
               w_state_nxt = S_IDLE;
               w_sub_nxt   = '0;
               w_cnt_nxt   = '0;
            end
         endcase

         // Dropping start clears the channel from any state.
         if (!start[k]) begin
            w_state_nxt = S_IDLE;
            w_sub_nxt   = '0;
            w_cnt_nxt   = '0;
            w_tick_nxt  = 1'b0;
            w_done_nxt  = 1'b0;
         end
      end

      // Channel state, counters, shadows and output registers.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_limit <= '0;
            r_sub   <= '0;
            r_cnt   <= '0;
            r_tick  <= 1'b0;
            r_done  <= 1'b0;
         end else begin
            r_state <= w_state_nxt;
            r_div   <= w_div_nxt;
            r_limit <= w_limit_nxt;
            r_sub   <= w_sub_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tick  <= w_tick_nxt;
            r_done  <= w_done_nxt;
         end
      end

      assign ticks_o[k*CNT_W +: CNT_W] = r_cnt;
      assign tick_o[k]                 = r_tick;
      assign done_o[k]                 = r_done;
   end

endmodule
`default_nettype wire

// File: tb/tb_lcd_tick_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lcd_tick_timer
//  Description : Self-checking bench for lcd_tick_timer. A reference model
//                derives each channel's outputs from the number of edges
//                elapsed since start and the latched period/limit/mode.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_tick_timer;
   localparam int NCH   = 2;
   localparam int DIV_W = 20;
   localparam int CNT_W = 17;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [NCH-1:0]       start;
   logic [NCH*DIV_W-1:0] div_i;
   logic [NCH*CNT_W-1:0] limit_i;
   logic [NCH-1:0]       mode;
   logic [NCH*CNT_W-1:0] ticks_o;
   logic [NCH-1:0]       tick_o;
   logic [NCH-1:0]       done_o;

   int n_assert = 0;
   int n_fail   = 0;

   lcd_tick_timer #(.NCH(NCH), .DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .div_i   (div_i),
      .limit_i (limit_i),
      .mode    (mode),
      .ticks_o (ticks_o),
      .tick_o  (tick_o),
      .done_o  (done_o)
   );

   always #5 clk = ~clk;

   // Reference model: run flag, edges since start, latched parameters.
   bit m_run [NCH];
   int m_n   [NCH];
   int m_d   [NCH];
   int m_l   [NCH];
   bit m_w   [NCH];

   // Model update on each sampling edge (and asynchronously on reset).
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NCH; i++) m_run[i] <= 1'b0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (!start[i]) begin
               m_run[i] <= 1'b0;
            end else if (!m_run[i]) begin
               m_run[i] <= 1'b1;
               m_n[i]   <= 0;
               m_d[i]   <= int'(div_i[i*DIV_W +: DIV_W]);
               m_l[i]   <= int'(limit_i[i*CNT_W +: CNT_W]);
`ifdef TICK_WRAP_MODE_EN
               m_w[i]   <= mode[i];
`else
               m_w[i]   <= 1'b0;
`endif
            end else begin
               m_n[i] <= m_n[i] + 1;
            end
         end
      end
   end

   function automatic void model_out(input int i, output int t, output bit tk, output bit dn);
      int p, k;
      bit edge_hit;
      t = 0; tk = 1'b0; dn = 1'b0;
      if (m_run[i]) begin
         p        = m_d[i] + 1;
         k        = m_n[i] / p;
         edge_hit = (m_n[i] > 0) && (m_n[i] % p == 0);
         if (m_w[i]) begin
            t  = k % (m_l[i] + 1);
            tk = edge_hit;
            dn = edge_hit && (k % (m_l[i] + 1) == 0);
         end else begin
            t  = (k < m_l[i]) ? k : m_l[i];
            tk = edge_hit && (k <= m_l[i]);
            dn = (k >= m_l[i]);
         end
      end
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      int t;
      bit tk, dn;
      for (int i = 0; i < NCH; i++) begin
         model_out(i, t, tk, dn);
         chk($sformatf("ticks_ch%0d t=%0t", i, $time), 64'(ticks_o[i*CNT_W +: CNT_W]), 64'(t));
         chk($sformatf("tick_ch%0d t=%0t", i, $time),  64'(tick_o[i]), 64'(tk));
         chk($sformatf("done_ch%0d t=%0t", i, $time),  64'(done_o[i]), 64'(dn));
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         check_all();
      end
   endtask

   task automatic set_ch(input int i, input int d, input int l, input bit m);
      div_i[i*DIV_W +: DIV_W]   = DIV_W'(d);
      limit_i[i*CNT_W +: CNT_W] = CNT_W'(l);
      mode[i]                   = m;
   endtask

   initial begin
      rst_n = 1'b0; start = '0; div_i = '0; limit_i = '0; mode = '0;

      // Reset state
      @(posedge clk); #1;
      chk("reset_ticks", 64'(ticks_o), 64'(0));
      chk("reset_tick",  64'(tick_o),  64'(0));
      chk("reset_done",  64'(done_o),  64'(0));
      rst_n = 1'b1;
      cyc(2);

      // Saturate: div=3 limit=5 on channel 0
      set_ch(0, 3, 5, 1'b0);
      start[0] = 1'b1;
      cyc(25);                               // edges 0..24
      chk("sat_final_ticks", 64'(ticks_o[0 +: CNT_W]), 64'(5));
      chk("sat_final_done",  64'(done_o[0]), 64'(1));
      chk("sat_no_tick_24",  64'(tick_o[0]), 64'(0));
      start[0] = 1'b0;
      cyc(1);
      chk("sat_clear", 64'(ticks_o[0 +: CNT_W]), 64'(0));

      // Wrap stimulus on channel 1: div=1 limit=2 mode=1
      set_ch(1, 1, 2, 1'b1);
      start[1] = 1'b1;
      cyc(15);                               // edges 0..14
`ifdef TICK_WRAP_MODE_EN
      chk("wrap_edge14_ticks", 64'(ticks_o[CNT_W +: CNT_W]), 64'(1));
      chk("wrap_edge14_done",  64'(done_o[1]), 64'(0));
`else
      chk("nowrap_edge14_ticks", 64'(ticks_o[CNT_W +: CNT_W]), 64'(2));
      chk("nowrap_edge14_done",  64'(done_o[1]), 64'(1));
`endif
      start[1] = 1'b0;
      cyc(1);

      // div=0 limit=0 saturate: immediate done, no tick
      set_ch(0, 0, 0, 1'b0);
      start[0] = 1'b1;
      cyc(1);
      chk("lim0_done",  64'(done_o[0]), 64'(1));
      chk("lim0_tick",  64'(tick_o[0]), 64'(0));
      cyc(3);
      start[0] = 1'b0;
      cyc(1);

      // Mid-run div change ignored until restart
      set_ch(0, 3, 4, 1'b0);
      start[0] = 1'b1;
      cyc(6);
      set_ch(0, 7, 4, 1'b0);
      cyc(20);
      start[0] = 1'b0;                        // one-cycle low pulse restarts
      cyc(1);
      start[0] = 1'b1;
      cyc(42);
      start = '0;
      cyc(1);

      // Both channels running, channel 0 dropped at edge 10
      set_ch(0, 2, 20, 1'b0);
      set_ch(1, 1, 30, 1'b1);
      start = 2'b11;
      cyc(10);                               // edges 0..9
      start[0] = 1'b0;
      cyc(1);                                // edge 10
      chk("drop_ch0_ticks", 64'(ticks_o[0 +: CNT_W]), 64'(0));
      chk("drop_ch1_ticks", 64'(ticks_o[CNT_W +: CNT_W]), 64'(5));
      cyc(10);

      // Asynchronous reset between edges mid-count
      start[0] = 1'b1;
      cyc(7);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst_ticks", 64'(ticks_o), 64'(0));
      chk("async_rst_tick",  64'(tick_o),  64'(0));
      chk("async_rst_done",  64'(done_o),  64'(0));
      cyc(2);
      rst_n = 1'b1;
      cyc(1);                                // new edge 0
      chk("post_rst_ticks", 64'(ticks_o), 64'(0));
      cyc(12);

      // Randomized traffic against the model
      repeat (400) begin
         for (int i = 0; i < NCH; i++) begin
            if ($urandom_range(0, 7) == 0) start[i] = ~start[i];
            if ($urandom_range(0, 3) == 0)
               set_ch(i, int'($urandom_range(0, 4)), int'($urandom_range(0, 5)),
                      1'($urandom_range(0, 1)));
         end
         cyc(1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/lcd_tick_timer.md
# lcd_tick_timer

Multi-channel, runtime-programmable tick timebase for the LCD/display control path. Each channel divides `clk` by a programmable period, counts the resulting ticks up to a programmable limit, and either saturates (one-shot) or wraps (free-running). Sits between the button/command front end and the LCD sequencer. It supplies delay counts, tick strobes and completion flags per channel, so that one instance serves several timing consumers.

## Interface
- `NCH`, 2, number of independent channels
- `DIV_W`, 20, width of the per-channel clock divider value
- `CNT_W`, 17, width of the per-channel tick counter and limit
- `clk`  input  1  system clock (25 MHz nominal)
- `rst_n`  input  1  reset, asynchronous assert, active-low; one clock domain only
- `start`  input  NCH  per-channel level enable; high = run, low = clear
- `div_i`  input  NCH*DIV_W  per-channel period; one tick every `div+1` clk cycles; channel k in bits [k*DIV_W +: DIV_W]
- `limit_i`  input  NCH*CNT_W  per-channel terminal tick count; same packing with CNT_W
- `mode`  input  NCH  per-channel: 0 = saturate at limit, 1 = wrap to 0 after limit
- `ticks_o`  output  NCH*CNT_W  current tick count per channel
- `tick_o`  output  NCH  one-cycle strobe on every tick increment or wrap
- `done_o`  output  NCH  saturate: level, limit reached; wrap: one-cycle pulse on wrap

## Operation
- Each channel is fully independent. State is held in a per-channel FSM with the states IDLE, RUN and DONE.
- IDLE: sub-counter = 0, count = 0, all channel outputs are 0. If `start`=1 at a clk edge, the channel latches `div_i`, `limit_i` and `mode` into shadow registers and moves to RUN.
- RUN: the sub-counter increments each cycle. When sub == latched div, the sub-counter returns to 0 and a tick occurs:
  - saturate mode: count += 1; `tick_o` pulses. If the new count == limit, the channel enters DONE and `done_o` rises on that same edge.
  - wrap mode: if count == limit, count goes to 0 and both `tick_o` and `done_o` pulse; otherwise count += 1 and `tick_o` pulses.
- DONE (saturate only): the counters freeze, `ticks_o` holds the limit, `done_o` stays 1 and no further `tick_o` pulses are issued.
- `start`=0 in any state: on the next edge the channel returns to IDLE and the count, sub-counter, `tick_o` and `done_o` clear.
- Changes to `div_i`, `limit_i` or `mode` while the channel is in RUN or DONE are ignored. New values take effect only after `start` is dropped and raised again.
- Limit = 0 in saturate mode: the channel goes IDLE→DONE directly and asserts `done_o`, with no tick.
- Limit = 0 in wrap mode: every tick is a wrap; `ticks_o` stays 0, and `tick_o` and `done_o` pulse every `div+1` cycles.
- `div`=0 gives one tick per clk cycle.
- Count arithmetic is unsigned CNT_W bits. The count never exceeds the latched limit, so it cannot overflow.

## Timing
- Reset (`rst_n`=0) asynchronously forces every channel to IDLE and every output bit to 0.
- Edge 0 is the first edge where `start`=1 is sampled in IDLE; RUN is entered at edge 0.
- The first tick occurs at edge div+1, and subsequent ticks follow every div+1 edges. `ticks_o` and `tick_o` update on the same edge, with no additional register lag.
- In saturate mode, `done_o` rises at edge limit*(div+1).
- `start` falling is sampled at edge F; the outputs are 0 after edge F.
- A `start` low pulse of one cycle is sufficient to restart a channel.
- Reset released mid-operation: the channel remains in IDLE until `start` is sampled high.

## Configuration
- `TICK_WRAP_MODE_EN` defined: per-channel wrap mode is implemented as described above.
- `TICK_WRAP_MODE_EN` undefined: the `mode` port is present but ignored, and every channel behaves in saturate mode. The wrap logic and the mode shadow register are not synthesised.

## Test plan
- Channel 0, div=3, limit=5, mode=0, `start` held high → `tick_o` pulses at edges 4, 8, 12, 16 and 20; `ticks_o` steps 1..5; `done_o` rises at edge 20 and holds; there is no pulse at edge 24.
- Channel 1, div=1, limit=2, mode=1 (macro defined) → `ticks_o` sequence 1, 2, 0, 1, 2, 0 with a change every 2 cycles; `done_o` pulses at edges 6 and 12.
- Same wrap stimulus with the macro undefined → `ticks_o` saturates at 2, `done_o` is held high from edge 4, and there is no wrap.
- div=0, limit=0 saturate → `done_o`=1 after edge 0 with `ticks_o`=0 and no `tick_o`. A mid-run change of `div_i` from 3 to 7 has no effect until `start` is toggled.
- Both channels running, `start[0]` dropped at edge 10 → channel 0 outputs are 0 after edge 10, while channel 1 ticks continue unchanged.
- `rst_n` asserted asynchronously between edges mid-count → all outputs read 0 immediately. After `rst_n` is released with `start` high, counting restarts from 0 and the first tick occurs div+1 edges later.
